// File: rtl/wrr_stream_arbiter.sv
// Weighted round-robin word-stream arbiter: N source FIFOs onto one SRAM FIFO write port.
// Optional statistics counters (TRANSFER_CNT, STALL_CNT) are built when ARB_STATS_EN is defined.
module wrr_stream_arbiter #(
    parameter int WIDTH       = 4,
    parameter int DATA_BITS   = 32,
    parameter int WEIGHT_BITS = 4,
    parameter int CH_BITS     = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [WIDTH-1:0]             WRITE_REQ,
    input  logic [WIDTH-1:0]             HOLD_REQ,
    input  logic [WIDTH*DATA_BITS-1:0]   DATA_IN,
    input  logic [WIDTH*WEIGHT_BITS-1:0] WEIGHT,
    input  logic                         READY_OUT,
    output logic [WIDTH-1:0]             READ_GRANT,
    output logic                         WRITE_OUT,
    output logic [DATA_BITS-1:0]         DATA_OUT,
    output logic [CH_BITS-1:0]           GRANT_ID
`ifdef ARB_STATS_EN
    ,
    output logic [WIDTH*32-1:0]          TRANSFER_CNT,
    output logic [31:0]                  STALL_CNT
`endif
);
    // One extra bit lets a held burst count past the largest weight before saturating.
    localparam int CNT_BITS = WEIGHT_BITS + 1;

    typedef enum logic {IDLE, GRANT} state_e;

    state_e                 state_q, state_d;
    logic [CH_BITS-1:0]     cur_q, cur_d;
    logic [CH_BITS-1:0]     last_q, last_d;
    logic [WEIGHT_BITS-1:0] lim_q, lim_d;
    logic [CNT_BITS-1:0]    burst_cnt_q, burst_cnt_d;

    logic [WEIGHT_BITS-1:0] weight_a [WIDTH];
    logic [DATA_BITS-1:0]   data_a [WIDTH];
    logic [CH_BITS-1:0]     pick;
    logic                   found;
    logic [CNT_BITS-1:0]    cnt_inc;
    logic                   transfer;

    always_comb begin
        for (int c = 0; c < WIDTH; c++) begin
            weight_a[c] = WEIGHT[c*WEIGHT_BITS +: WEIGHT_BITS];
            data_a[c]   = DATA_IN[c*DATA_BITS +: DATA_BITS];
        end
    end

    // First requester strictly after the last served channel, wrapping modulo WIDTH.
    always_comb begin
        logic [CH_BITS-1:0] idx;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= WIDTH; i++) begin
            idx = CH_BITS'((int'(last_q) + i) % WIDTH);
            if (!found && WRITE_REQ[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // NOTE: every signal written below gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        lim_d       = lim_q;
        burst_cnt_d = burst_cnt_q;
        READ_GRANT  = '0;
        WRITE_OUT   = 1'b0;
        DATA_OUT    = '0;
        transfer    = 1'b0;
        cnt_inc     = burst_cnt_q + CNT_BITS'(1);

        case (state_q)
            IDLE: begin
                if (found) begin
                    cur_d       = pick;
                    lim_d       = (weight_a[pick] == '0) ? WEIGHT_BITS'(1) : weight_a[pick];
                    burst_cnt_d = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                WRITE_OUT         = WRITE_REQ[cur_q];
                DATA_OUT          = data_a[cur_q];
                transfer          = WRITE_REQ[cur_q] & READY_OUT;
                READ_GRANT[cur_q] = transfer;
                if (transfer && (burst_cnt_q != '1)) begin
                    burst_cnt_d = cnt_inc;
                end
                if (!HOLD_REQ[cur_q] &&
                    (!WRITE_REQ[cur_q] || (transfer && (cnt_inc == {1'b0, lim_q})))) begin
                    last_d  = cur_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pop strobes and write data must drop in the very cycle reset is asserted.
        if (RST) begin
            READ_GRANT = '0;
            WRITE_OUT  = 1'b0;
            DATA_OUT   = '0;
        end
    end

    assign GRANT_ID = RST ? '0 : cur_q;

    // NOTE: state registers use non-blocking assignments only; reset is sampled on the clock edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            last_q      <= CH_BITS'(WIDTH - 1);
            lim_q       <= WEIGHT_BITS'(1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            lim_q       <= lim_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] transfer_cnt_q [WIDTH];
    logic [31:0] transfer_cnt_d [WIDTH];
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        for (int c = 0; c < WIDTH; c++) begin
            transfer_cnt_d[c] = transfer_cnt_q[c];
            if (READ_GRANT[c] && (transfer_cnt_q[c] != '1)) begin
                transfer_cnt_d[c] = transfer_cnt_q[c] + 32'd1;
            end
            TRANSFER_CNT[c*32 +: 32] = transfer_cnt_q[c];
        end
        stall_cnt_d = stall_cnt_q;
        if (WRITE_OUT && !READY_OUT && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int c = 0; c < WIDTH; c++) transfer_cnt_q[c] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int c = 0; c < WIDTH; c++) transfer_cnt_q[c] <= transfer_cnt_d[c];
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wrr_stream_arbiter.sv
// Directed self-checking bench for wrr_stream_arbiter (4 channels, 32-bit words).
// Source FIFOs are modelled in the bench; expected grant sequences are written out per cycle.
module tb_wrr_stream_arbiter;
    localparam int WIDTH = 4;
    localparam int DB    = 32;
    localparam int WB    = 4;
    localparam int CB    = 2;

    logic                clk;
    logic                rst;
    logic [WIDTH-1:0]    write_req;
    logic [WIDTH-1:0]    hold_req;
    logic [WIDTH*DB-1:0] data_in;
    logic [WIDTH*WB-1:0] weight;
    logic                ready_out;
    logic [WIDTH-1:0]    read_grant;
    logic                write_out;
    logic [DB-1:0]       data_out;
    logic [CB-1:0]       grant_id;
`ifdef ARB_STATS_EN
    logic [WIDTH*32-1:0] transfer_cnt;
    logic [31:0]         stall_cnt;
`endif

    wrr_stream_arbiter #(
        .WIDTH(WIDTH), .DATA_BITS(DB), .WEIGHT_BITS(WB), .CH_BITS(CB)
    ) dut (
        .CLK(clk), .RST(rst),
        .WRITE_REQ(write_req), .HOLD_REQ(hold_req), .DATA_IN(data_in), .WEIGHT(weight),
        .READY_OUT(ready_out), .READ_GRANT(read_grant), .WRITE_OUT(write_out),
        .DATA_OUT(data_out), .GRANT_ID(grant_id)
`ifdef ARB_STATS_EN
        , .TRANSFER_CNT(transfer_cnt), .STALL_CNT(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Source FIFO model: words remaining, pop pointer, and request mask per channel.
    int   cnt  [WIDTH];
    int   ptr  [WIDTH];
    int   eptr [WIDTH];
    logic mask [WIDTH];

    // Expected channel per cycle: >=0 transfer, -1 no word offered, -2 offered but stalled.
    int exp_ch [$];
    int exp_id [$];

    function automatic logic [31:0] word(input int c, input int k);
        return 32'hA500_0000 + 32'(c << 8) + 32'(k);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int c = 0; c < WIDTH; c++) begin
            write_req[c]        = (cnt[c] > 0) && !mask[c];
            data_in[c*DB +: DB] = word(c, ptr[c]);
        end
    endtask

    task automatic load(input int c, input int n, input logic [WB-1:0] w);
        cnt[c]  = n;
        ptr[c]  = 0;
        eptr[c] = 0;
        weight[c*WB +: WB] = w;
    endtask

    // Sample at the current (settled) point, advance one clock, pop granted words, settle.
    task automatic cycle();
        logic [WIDTH-1:0] g;
        g = read_grant;
        chk("onehot_grant", 64'($onehot0(read_grant)), 64'd1);
        chk("grant_qualified", 64'((read_grant == '0) || (write_out && ready_out)), 64'd1);
        @(posedge clk);
        #1;
        for (int c = 0; c < WIDTH; c++) begin
            if (g[c]) begin
                cnt[c]--;
                ptr[c]++;
            end
        end
        drive();
        #1;
    endtask

    task automatic check_seq(input string tag);
        for (int i = 0; i < exp_ch.size(); i++) begin
            int ch = exp_ch[i];
            int id = exp_id[i];
            string t = $sformatf("%s[%0d]", tag, i);
            if (ch >= 0) begin
                chk({t, ".grant"}, 64'(read_grant), 64'(1 << ch));
                chk({t, ".wout"}, 64'(write_out), 64'd1);
                chk({t, ".data"}, 64'(data_out), 64'(word(ch, eptr[ch])));
                eptr[ch]++;
            end else if (ch == -2) begin
                chk({t, ".grant"}, 64'(read_grant), 64'd0);
                chk({t, ".wout"}, 64'(write_out), 64'd1);
                chk({t, ".data"}, 64'(data_out), 64'(word(id, eptr[id])));
            end else begin
                chk({t, ".grant"}, 64'(read_grant), 64'd0);
                chk({t, ".wout"}, 64'(write_out), 64'd0);
            end
            chk({t, ".id"}, 64'(grant_id), 64'(id));
            cycle();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int c = 0; c < WIDTH; c++) begin
            cnt[c]  = 0;
            ptr[c]  = 0;
            eptr[c] = 0;
            mask[c] = 1'b0;
            weight[c*WB +: WB] = WB'(1);
        end
        hold_req  = '0;
        ready_out = 1'b1;
        drive();
        cycle();
        cycle();
    endtask

    task automatic release_reset();
        rst = 1'b0;
        drive();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        hold_req  = '0;
        ready_out = 1'b1;
        weight    = '0;
        write_req = '0;
        data_in   = '0;
        #1;

        // Reset state with a live request: everything forced to 0.
        do_reset();
        load(2, 5, 4'd3);
        drive();
        cycle();
        chk("rst.grant", 64'(read_grant), 64'd0);
        chk("rst.wout", 64'(write_out), 64'd0);
        chk("rst.data", 64'(data_out), 64'd0);
        chk("rst.id", 64'(grant_id), 64'd0);

        // Single channel ch2, 5 words, weight 3: 3-word burst, bubble, 2-word burst.
        release_reset();
        exp_ch = '{-1, 2, 2, 2, -1, 2, 2, -1, -1};
        exp_id = '{ 0, 2, 2, 2,  2, 2, 2,  2,  2};
        check_seq("single");

        // Round robin, all weights 1: 0,1,2,3,0,1,2,3 with bubbles over 16 cycles.
        do_reset();
        for (int c = 0; c < WIDTH; c++) load(c, 8, 4'd1);
        release_reset();
        exp_ch = '{-1, 0, -1, 1, -1, 2, -1, 3, -1, 0, -1, 1, -1, 2, -1, 3};
        exp_id = '{ 0, 0,  0, 1,  1, 2,  2, 3,  3, 0,  0, 1,  1, 2,  2, 3};
        check_seq("rr");
`ifdef ARB_STATS_EN
        for (int c = 0; c < WIDTH; c++)
            chk($sformatf("rr.transfer_cnt%0d", c), 64'(transfer_cnt[c*32 +: 32]), 64'd2);
`endif

        // Weighted: ch0 weight 4, ch1 weight 1.
        do_reset();
        load(0, 12, 4'd4);
        load(1, 6, 4'd1);
        release_reset();
        exp_ch = '{-1, 0, 0, 0, 0, -1, 1, -1, 0, 0, 0, 0, -1, 1, -1};
        exp_id = '{ 0, 0, 0, 0, 0,  0, 1,  1, 0, 0, 0, 0,  0, 1,  1};
        check_seq("wrr");

        // Hold: ch0 held with weight 1, request gap of 2 cycles, ch1 waiting.
        do_reset();
        load(0, 4, 4'd1);
        load(1, 3, 4'd1);
        hold_req[0] = 1'b1;
        release_reset();
        exp_ch = '{-1, 0, 0};
        exp_id = '{ 0, 0, 0};
        check_seq("hold.a");
        mask[0] = 1'b1;
        drive();
        #1;
        exp_ch = '{-1, -1};
        exp_id = '{ 0,  0};
        check_seq("hold.gap");
        mask[0] = 1'b0;
        drive();
        #1;
        exp_ch = '{0, 0, -1, -1};
        exp_id = '{0, 0,  0,  0};
        check_seq("hold.b");
        hold_req[0] = 1'b0;
        drive();
        #1;
        exp_ch = '{-1, -1, 1, -1};
        exp_id = '{ 0,  0, 1,  1};
        check_seq("hold.rel");

        // Backpressure: ch3 weight 4, READY_OUT low for 5 cycles mid-burst.
        do_reset();
        load(3, 6, 4'd4);
        release_reset();
        exp_ch = '{-1, 3, 3};
        exp_id = '{ 0, 3, 3};
        check_seq("bp.a");
        ready_out = 1'b0;
        drive();
        #1;
        exp_ch = '{-2, -2, -2, -2, -2};
        exp_id = '{ 3,  3,  3,  3,  3};
        check_seq("bp.stall");
        ready_out = 1'b1;
        drive();
        #1;
        exp_ch = '{3, 3, -1, 3};
        exp_id = '{3, 3,  3, 3};
        check_seq("bp.resume");
`ifdef ARB_STATS_EN
        chk("bp.stall_cnt", 64'(stall_cnt), 64'd5);
`endif

        // Reset mid-burst: outputs drop at once, nothing popped, restart from lowest requester.
        rst = 1'b1;
        drive();
        #1;
        chk("midrst.grant", 64'(read_grant), 64'd0);
        chk("midrst.wout", 64'(write_out), 64'd0);
        chk("midrst.data", 64'(data_out), 64'd0);
        chk("midrst.id", 64'(grant_id), 64'd0);
        load(1, 2, 4'd1);
        drive();
        cycle();
        chk("midrst.hold_grant", 64'(read_grant), 64'd0);
        chk("midrst.hold_id", 64'(grant_id), 64'd0);
        release_reset();
        exp_ch = '{-1, 1, -1, 3};
        exp_id = '{ 0, 1,  1, 3};
        check_seq("midrst.after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
